// File: rtl/accel_bcd_seq.sv
// -----------------------------------------------------------------------------
// accel_bcd_seq
//
// Sequential signed-binary to BCD converter for accelerometer readout.
// A two's-complement sample is taken over a valid/ready handshake, its
// magnitude is scaled by 2^SCALE_SHIFT into display units, and the scaled
// magnitude is converted to DIGITS BCD digits by an iterative shift-add-3
// (double dabble) datapath, one bit per clock. The sign, the digits and an
// overflow flag are presented over a second valid/ready handshake.
//
// Parameters
//   IN_W        width of the signed input sample (>= 2)
//   SCALE_SHIFT output scaling, magnitude multiplied by 2^SCALE_SHIFT (0..4)
//   DIGITS      number of BCD digits produced (1..6)
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a sample
//   in_ready   block can accept a sample (state IDLE)
//   in_data    signed two's-complement sample, IN_W bits
//   out_valid  bcd/negative/overflow hold a completed conversion
//   out_ready  consumer takes the result
//   bcd        DIGITS packed digits, bcd[3:0] ones, next nibble tens, ...
//   negative   the converted sample was negative
//   overflow   scaled magnitude exceeded 10^DIGITS-1; bcd saturated to all 9s
//   busy       conversion in progress (state SHIFT)
// -----------------------------------------------------------------------------
module accel_bcd_seq #(
  parameter int IN_W        = 10,
  parameter int SCALE_SHIFT = 2,
  parameter int DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic                  busy
);

  // Width of the scaled magnitude; also the number of shift cycles.
  localparam int PROD_W = IN_W + SCALE_SHIFT;
  localparam int CNT_W  = (PROD_W > 1) ? $clog2(PROD_W) : 1;
  localparam int BCD_W  = 4 * DIGITS;

  localparam logic [IN_W-1:0]  IN_ONE    = IN_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PROD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic               neg_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [PROD_W-1:0]  shift_r;
  logic [BCD_W-1:0]   digits_r;

  // ---------------------------------------------------------------------------
  // Input magnitude. Negating in IN_W unsigned bits maps the most negative
  // sample onto 2^(IN_W-1), which still fits, so no extra bit is needed.
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] mag;
  assign mag = in_data[IN_W-1] ? (~in_data + IN_ONE) : in_data;

  // ---------------------------------------------------------------------------
  // One double-dabble step: add 3 to every digit >= 5, then shift the whole
  // {digits, shift_r} chain left by one. A 1 leaving the top digit means the
  // running value has reached 10^DIGITS, which is sticky for the rest of the
  // conversion. The top-digit >= 10 test catches any value whose leading digit
  // cannot be represented even without a carry.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0]  corr;
  logic [BCD_W-1:0]  digits_nxt;
  logic [PROD_W-1:0] shift_nxt;
  logic              carry;
  logic              ovf_nxt;

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    corr = digits_r;
    for (int d = 0; d < DIGITS; d++) begin
      if (digits_r[4*d +: 4] >= 4'd5) begin
        corr[4*d +: 4] = digits_r[4*d +: 4] + 4'd3;
      end
    end
    {carry, digits_nxt} = {corr, shift_r[PROD_W-1]};
    shift_nxt           = {shift_r[PROD_W-2:0], 1'b0};
    ovf_nxt             = ovf_r | carry | (digits_nxt[BCD_W-1 -: 4] >= 4'd10);
  end

  // Handshake/status outputs decoded straight from the state register.
  assign in_ready = (state_r == ST_IDLE);
  assign busy     = (state_r == ST_SHIFT);

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers. Result registers load only on the
  // SHIFT->DONE transition and hold while the consumer stalls.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      cnt_r     <= '0;
      shift_r   <= '0;
      digits_r  <= '0;
      out_valid <= 1'b0;
      bcd       <= '0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            neg_r    <= in_data[IN_W-1];
            shift_r  <= PROD_W'(mag) << SCALE_SHIFT;
            digits_r <= '0;
            ovf_r    <= 1'b0;
            cnt_r    <= CNT_LAST;
            state_r  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          digits_r <= digits_nxt;
          shift_r  <= shift_nxt;
          ovf_r    <= ovf_nxt;
          if (cnt_r == '0) begin
            // Final bit shifted in: publish the result from this step's
            // next-state values so the last carry is not missed.
            bcd       <= ovf_nxt ? ALL_NINES : digits_nxt;
            overflow  <= ovf_nxt;
            negative  <= neg_r;
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_accel_bcd_seq
//
// Directed bench for accel_bcd_seq. Instance u_a uses the default parameters
// (IN_W=10, SCALE_SHIFT=2, DIGITS=4); instance u_b uses DIGITS=3 to exercise
// saturation. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_accel_bcd_seq;

  logic clk;
  logic rst_n;

  // Instance A: defaults
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [9:0]  a_in_data;
  logic [15:0] a_bcd;
  logic        a_negative, a_overflow, a_busy;

  // Instance B: DIGITS=3
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [9:0]  b_in_data;
  logic [11:0] b_bcd;
  logic        b_negative, b_overflow, b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  accel_bcd_seq #(.IN_W(10), .SCALE_SHIFT(2), .DIGITS(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd(a_bcd), .negative(a_negative), .overflow(a_overflow), .busy(a_busy)
  );

  accel_bcd_seq #(.IN_W(10), .SCALE_SHIFT(2), .DIGITS(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd(b_bcd), .negative(b_negative), .overflow(b_overflow), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Drive one sample into u_a, wait (bounded) for out_valid, report what was
  // observed, then complete the output handshake. lat = -1 on timeout.
  // ---------------------------------------------------------------------------
  task automatic run_a(input logic [9:0] data, output logic [15:0] o_bcd,
                       output logic o_neg, output logic o_ovf, output int lat);
    int cycles;
    @(negedge clk);
    a_in_valid  = 1'b1;
    a_in_data   = data;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    cycles = 0;
    while (!a_out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    lat   = a_out_valid ? cycles : -1;
    o_bcd = a_bcd;
    o_neg = a_negative;
    o_ovf = a_overflow;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [9:0] data, output logic [11:0] o_bcd,
                       output logic o_neg, output logic o_ovf, output int lat);
    int cycles;
    @(negedge clk);
    b_in_valid  = 1'b1;
    b_in_data   = data;
    b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b0;
    cycles = 0;
    while (!b_out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    lat   = b_out_valid ? cycles : -1;
    o_bcd = b_bcd;
    o_neg = b_negative;
    o_ovf = b_overflow;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    n_cmp++; if (a_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_bcd got=%h exp=0000", a_bcd); end
    n_cmp++; if ({a_negative, a_overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b exp=00", {a_negative, a_overflow}); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid got=%b exp=0", b_out_valid); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic();
    logic [9:0]  vin  [4] = '{10'h1FF, 10'h200, 10'h3FF, 10'h000};
    logic [15:0] vbcd [4] = '{16'h2044, 16'h2048, 16'h0004, 16'h0000};
    logic        vneg [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] o_bcd;
    logic        o_neg, o_ovf;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_a(vin[i], o_bcd, o_neg, o_ovf, lat);
      n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL basic_latency[%0d] got=%0d exp=12", i, lat); end
      n_cmp++; if (o_bcd !== vbcd[i]) begin n_bad++; $display("FAIL basic_bcd[%0d] got=%h exp=%h", i, o_bcd, vbcd[i]); end
      n_cmp++; if (o_neg !== vneg[i]) begin n_bad++; $display("FAIL basic_negative[%0d] got=%b exp=%b", i, o_neg, vneg[i]); end
      n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_overflow[%0d] got=%b exp=0", i, o_ovf); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int cycles;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 10'h1FF; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    n_cmp++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_busy_after_accept got busy=%b in_ready=%b exp busy=1 in_ready=0", a_busy, a_in_ready); end
    cycles = 0;
    while (!a_out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++; if (cycles !== 12) begin n_bad++; $display("FAIL bp_latency got=%0d exp=12", cycles); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_in_done got=%b exp=0", a_busy); end
    for (int i = 0; i < 20; i++) begin
      // Offer a new sample mid-stall; it must be ignored.
      a_in_valid = (i == 7);
      a_in_data  = 10'h3FF;
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_bcd !== 16'h2044 || a_negative !== 1'b0 ||
          a_overflow !== 1'b0 || a_in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got v=%b bcd=%h n=%b o=%b rdy=%b exp v=1 bcd=2044 n=0 o=0 rdy=0",
                 i, a_out_valid, a_bcd, a_negative, a_overflow, a_in_ready);
      end
      @(negedge clk);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", a_out_valid, a_in_ready); end
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0 || a_bcd !== 16'h2044) begin n_bad++; $display("FAIL bp_no_stale_accept got busy=%b bcd=%h exp busy=0 bcd=2044", a_busy, a_bcd); end
    // out_ready while idle is harmless
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_out_ready got v=%b rdy=%b exp v=0 rdy=1", a_out_valid, a_in_ready); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_digits3();
    logic [9:0]  vin  [3] = '{10'h1FF, 10'h0F9, 10'h0FA};
    logic [11:0] vbcd [3] = '{12'h999, 12'h996, 12'h999};
    logic        vovf [3] = '{1'b1, 1'b0, 1'b1};
    logic [11:0] o_bcd;
    logic        o_neg, o_ovf;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_b(vin[i], o_bcd, o_neg, o_ovf, lat);
      n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL d3_latency[%0d] got=%0d exp=12", i, lat); end
      n_cmp++; if (o_bcd !== vbcd[i]) begin n_bad++; $display("FAIL d3_bcd[%0d] got=%h exp=%h", i, o_bcd, vbcd[i]); end
      n_cmp++; if (o_ovf !== vovf[i]) begin n_bad++; $display("FAIL d3_overflow[%0d] got=%b exp=%b", i, o_ovf, vovf[i]); end
      n_cmp++; if (o_neg !== 1'b0) begin n_bad++; $display("FAIL d3_negative[%0d] got=%b exp=0", i, o_neg); end
    end
    n_cmp++; if (b_in_ready !== 1'b1 || b_busy !== 1'b0) begin n_bad++; $display("FAIL d3_idle got rdy=%b busy=%b exp rdy=1 busy=0", b_in_ready, b_busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_shift();
    logic [15:0] o_bcd;
    logic        o_neg, o_ovf;
    int          lat;
    int          seen;
    // u_a holds bcd=2044 from the previous test, so a clear is observable.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 10'h3FF; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before got=%b exp=1", a_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0 ||
        a_bcd !== 16'h0000 || a_negative !== 1'b0 || a_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs got busy=%b rdy=%b v=%b bcd=%h n=%b o=%b exp 0 1 0 0000 0 0",
               a_busy, a_in_ready, a_out_valid, a_bcd, a_negative, a_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_out_valid got=%0d exp=0", seen); end
    run_a(10'h001, o_bcd, o_neg, o_ovf, lat);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL rst_fresh_latency got=%0d exp=12", lat); end
    n_cmp++; if (o_bcd !== 16'h0004 || o_neg !== 1'b0 || o_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_fresh_result got bcd=%h n=%b o=%b exp 0004 0 0", o_bcd, o_neg, o_ovf); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    // Hand-computed: |x|*4 in decimal, sign from the sample.
    logic [9:0]  samp [8] = '{10'd100, 10'h39C, 10'd250, 10'd37,
                              10'h3DB, 10'd499, 10'd1,  10'h300};
    logic [15:0] ebcd [8] = '{16'h0400, 16'h0400, 16'h1000, 16'h0148,
                              16'h0148, 16'h1996, 16'h0004, 16'h1024};
    logic        eneg [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int cyc, acc_n, res_n, last_acc;
    cyc = 0; acc_n = 0; res_n = 0; last_acc = 0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = samp[0]; a_out_ready = 1'b1;
    while (res_n < 8 && cyc < 400) begin
      if (a_out_valid) begin
        n_cmp++;
        if (a_bcd !== ebcd[res_n] || a_negative !== eneg[res_n] || a_overflow !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_result[%0d] got bcd=%h n=%b o=%b exp bcd=%h n=%b o=0",
                   res_n, a_bcd, a_negative, a_overflow, ebcd[res_n], eneg[res_n]);
        end
        res_n++;
      end
      if (a_in_valid && a_in_ready) begin
        if (acc_n > 0) begin
          n_cmp++;
          if (cyc - last_acc !== 14) begin
            n_bad++;
            $display("FAIL b2b_spacing[%0d] got=%0d exp=14", acc_n, cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc_n++;
      end
      @(negedge clk);
      cyc++;
      a_in_valid = (acc_n < 8);
      if (acc_n < 8) a_in_data = samp[acc_n];
    end
    n_cmp++; if (res_n !== 8) begin n_bad++; $display("FAIL b2b_count got=%0d exp=8", res_n); end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_digits3();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
